// File: rtl/swc_rtu_rsp_dispatcher_pkg.sv
// Shared types and helpers for the RTU response dispatcher.
//   t_rtu_rsp        : canonical response record (mask, drop, prio) at maximum widths;
//                      the default entry type of swc_rtu_rsp_fifo
//   f_log2_size      : ceil(log2(size)), used for FIFO pointer widths
//   c_port_idx_width : width of the port index on the RTU engine stream
package swc_rtu_rsp_pkg;

    localparam int unsigned c_port_idx_width = 4;
    localparam int unsigned c_max_ports      = 16;
    localparam int unsigned c_max_prio_width = 8;

    typedef struct packed {
        logic [c_max_ports-1:0]      mask;
        logic                        drop;
        logic [c_max_prio_width-1:0] prio;
    } t_rtu_rsp;

    function automatic int unsigned f_log2_size(input int unsigned size);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(size)) r++;
        return r;
    endfunction

endpackage

// File: rtl/swc_rtu_rsp_dispatcher_if.sv
// Serialized response stream from the shared RTU lookup engine.
//   in_valid_i : engine presents a response
//   in_ready_o : dispatcher accepts it this cycle
//   in_port_i  : target port index
//   in_mask_i  : destination port mask
//   in_drop_i  : drop flag
//   in_prio_i  : priority
// Modports: master = RTU engine, slave = dispatcher.
interface swc_rtu_rsp_dispatcher_if
    import swc_rtu_rsp_pkg::*;
#(
    parameter int unsigned g_num_ports  = 7,
    parameter int unsigned g_prio_width = 3
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [c_port_idx_width-1:0] in_port_i;
    logic [g_num_ports-1:0]      in_mask_i;
    logic                        in_drop_i;
    logic [g_prio_width-1:0]     in_prio_i;

    modport master (
        output in_valid_i, in_port_i, in_mask_i, in_drop_i, in_prio_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i, in_port_i, in_mask_i, in_drop_i, in_prio_i,
        output in_ready_o
    );
endinterface

// File: rtl/swc_rtu_rsp_dispatcher_fifo.sv
// swc_rtu_rsp_fifo: single show-ahead FIFO of response records.
//   clk, rst_n : clock, asynchronous active-high reset
//   push, din  : write din (ignored when full)
//   pop        : drop head entry (ignored when empty)
//   head       : current head entry, meaningful only while !empty
//   full/empty : occupancy flags
// g_depth must be a power of two so pointers wrap naturally.
module swc_rtu_rsp_fifo
    import swc_rtu_rsp_pkg::*;
#(
    parameter type         t_entry = t_rtu_rsp,
    parameter int unsigned g_depth = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  t_entry din,
    output t_entry head,
    output logic   full,
    output logic   empty
);
    localparam int unsigned   c_aw    = f_log2_size(g_depth);
    localparam logic [c_aw:0] c_depth = g_depth[c_aw:0];

    t_entry          mem [g_depth];
    logic [c_aw-1:0] rd_ptr;
    logic [c_aw-1:0] wr_ptr;
    logic [c_aw:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == c_depth);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/swc_rtu_rsp_dispatcher.sv
// swc_rtu_rsp_dispatcher: demultiplexes the RTU engine response stream into
// per-port show-ahead FIFOs and presents each head on the core's valid/ack bus.
//   clk, rst_n          : clock, asynchronous active-high reset
//   in_bus (slave)      : response stream from the RTU engine
//   rtu_rsp_valid_o     : per-port head valid
//   rtu_rsp_ack_i       : per-port head consumed
//   rtu_dst_port_mask_o : per-port head mask, port p at [p*N +: N]
//   rtu_drop_o          : per-port head drop flag
//   rtu_prio_o          : per-port head priority, port p at [p*W +: W]
//   bad_port_cnt_o      : saturating count of responses with an invalid port index
//   filtered_cnt_o      : saturating count of filtered responses
//                         (only with SWC_RTU_RSP_DROP_FILTER_EN)
// Optional feature macro: SWC_RTU_RSP_DROP_FILTER_EN -- responses with drop=1 or an
// all-zero mask are consumed without queueing and are never blocked by a full FIFO.
module swc_rtu_rsp_dispatcher
    import swc_rtu_rsp_pkg::*;
#(
    parameter int unsigned g_num_ports  = 7,
    parameter int unsigned g_prio_width = 3,
    parameter int unsigned g_fifo_depth = 4,
    parameter int unsigned g_cnt_width  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    swc_rtu_rsp_dispatcher_if.slave             in_bus,
    output logic [g_num_ports-1:0]              rtu_rsp_valid_o,
    input  logic [g_num_ports-1:0]              rtu_rsp_ack_i,
    output logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o,
    output logic [g_num_ports-1:0]              rtu_drop_o,
    output logic [g_num_ports*g_prio_width-1:0] rtu_prio_o,
    output logic [g_cnt_width-1:0]              bad_port_cnt_o
`ifdef SWC_RTU_RSP_DROP_FILTER_EN
    ,
    output logic [g_cnt_width-1:0]              filtered_cnt_o
`endif
);
    localparam logic [c_port_idx_width:0] c_num_ports = g_num_ports[c_port_idx_width:0];

    typedef struct packed {
        logic [g_num_ports-1:0]  mask;
        logic                    drop;
        logic [g_prio_width-1:0] prio;
    } t_port_rsp;

    t_port_rsp              din;
    t_port_rsp              head [g_num_ports];
    logic [g_num_ports-1:0] push;
    logic [g_num_ports-1:0] full;
    logic [g_num_ports-1:0] empty;
    logic                   port_ok;
    logic                   sel_full;
    logic                   filt;
    logic                   ready;
    logic                   accept;

    assign din     = '{mask: in_bus.in_mask_i, drop: in_bus.in_drop_i, prio: in_bus.in_prio_i};
    assign port_ok = ({1'b0, in_bus.in_port_i} < c_num_ports);

    always_comb begin
        sel_full = 1'b0;
        for (int unsigned p = 0; p < g_num_ports; p++) begin
            if (in_bus.in_port_i == c_port_idx_width'(p)) sel_full = full[p];
        end
    end

`ifdef SWC_RTU_RSP_DROP_FILTER_EN
    assign filt = in_bus.in_drop_i | ~|in_bus.in_mask_i;
`else
    assign filt = 1'b0;
`endif

    // Readiness looks only at start-of-cycle fullness, so a same-cycle ack never
    // lets a push into a full FIFO.
    assign ready             = ~port_ok | filt | ~sel_full;
    assign in_bus.in_ready_o = ready;
    assign accept            = in_bus.in_valid_i & ready;

    for (genvar p = 0; p < g_num_ports; p++) begin : g_port
        assign push[p] = accept & ~filt & (in_bus.in_port_i == c_port_idx_width'(p));

        swc_rtu_rsp_fifo #(
            .t_entry (t_port_rsp),
            .g_depth (g_fifo_depth)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .pop   (rtu_rsp_ack_i[p]),
            .din   (din),
            .head  (head[p]),
            .full  (full[p]),
            .empty (empty[p])
        );

        assign rtu_rsp_valid_o[p]                              = ~empty[p];
        assign rtu_dst_port_mask_o[p*g_num_ports +: g_num_ports] = empty[p] ? '0 : head[p].mask;
        assign rtu_drop_o[p]                                   = ~empty[p] & head[p].drop;
        assign rtu_prio_o[p*g_prio_width +: g_prio_width]      = empty[p] ? '0 : head[p].prio;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bad_port_cnt_o <= '0;
        end else if (accept && !port_ok && bad_port_cnt_o != '1) begin
            bad_port_cnt_o <= bad_port_cnt_o + 1'b1;
        end
    end

`ifdef SWC_RTU_RSP_DROP_FILTER_EN
    // An invalid port index takes precedence: such responses count as bad, not filtered.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            filtered_cnt_o <= '0;
        end else if (accept && port_ok && filt && filtered_cnt_o != '1) begin
            filtered_cnt_o <= filtered_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_swc_rtu_rsp_dispatcher.sv
module tb_swc_rtu_rsp_dispatcher;
    localparam int unsigned N       = 7;
    localparam int unsigned PW      = 3;
    localparam int unsigned D       = 4;
    localparam int unsigned CW      = 16;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef SWC_RTU_RSP_DROP_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ack;
    logic [N-1:0]    rsp_drop;
    logic [N*N-1:0]  rsp_mask;
    logic [N*PW-1:0] rsp_prio;
    logic [CW-1:0]   bad_cnt;
`ifdef SWC_RTU_RSP_DROP_FILTER_EN
    logic [CW-1:0]   filt_cnt;
`endif

    swc_rtu_rsp_dispatcher_if #(.g_num_ports(N), .g_prio_width(PW)) bus ();

    swc_rtu_rsp_dispatcher #(
        .g_num_ports  (N),
        .g_prio_width (PW),
        .g_fifo_depth (D),
        .g_cnt_width  (CW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_bus              (bus),
        .rtu_rsp_valid_o     (rsp_valid),
        .rtu_rsp_ack_i       (rsp_ack),
        .rtu_dst_port_mask_o (rsp_mask),
        .rtu_drop_o          (rsp_drop),
        .rtu_prio_o          (rsp_prio),
        .bad_port_cnt_o      (bad_cnt)
`ifdef SWC_RTU_RSP_DROP_FILTER_EN
        ,
        .filtered_cnt_o      (filt_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [N-1:0]  mask;
        logic          drop;
        logic [PW-1:0] prio;
    } rsp_t;

    rsp_t        exp_q [N][$];
    int unsigned bad_m;
    int unsigned filt_m;
    logic        exp_ready;
    logic        pend_acc;
    logic [3:0]  pend_port;
    rsp_t        pend_rsp;
    int          n_checks;
    int          n_fail;

    function automatic logic is_filtered(input logic [N-1:0] m, input logic d);
        return FILTER_EN && (d || (m == '0));
    endfunction

    function automatic logic model_ready(input logic [3:0] port, input logic [N-1:0] m, input logic d);
        if (int'(port) >= N) return 1'b1;
        if (is_filtered(m, d)) return 1'b1;
        return exp_q[port].size() < D;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the response the model predicted would be taken at the edge just passed.
    task automatic commit();
        if (pend_acc) begin
            if (int'(pend_port) >= N) begin
                if (bad_m < CNT_MAX) bad_m++;
            end else if (is_filtered(pend_rsp.mask, pend_rsp.drop)) begin
                if (filt_m < CNT_MAX) filt_m++;
            end else begin
                exp_q[pend_port].push_back(pend_rsp);
            end
        end
        pend_acc = 1'b0;
    endtask

    task automatic step(input logic v, input logic [3:0] port, input logic [N-1:0] m,
                        input logic d, input logic [PW-1:0] pr, input logic [N-1:0] a);
        @(posedge clk);
        #1;
        commit();
        bus.in_valid_i = v;
        bus.in_port_i  = port;
        bus.in_mask_i  = m;
        bus.in_drop_i  = d;
        bus.in_prio_i  = pr;
        rsp_ack        = a;
        exp_ready      = model_ready(port, m, d);
        pend_acc       = v && exp_ready && !rst_n;
        pend_port      = port;
        pend_rsp       = '{mask: m, drop: d, prio: pr};
    endtask

    task automatic idle(input int unsigned n, input logic [N-1:0] a);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 4'd0, '0, 1'b0, '0, a);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        commit();
        rst_n          = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_port_i  = '0;
        bus.in_mask_i  = '0;
        bus.in_drop_i  = 1'b0;
        bus.in_prio_i  = '0;
        rsp_ack        = '0;
        #1;
        check("async_reset_valid", 64'(rsp_valid), 64'd0);
        check("async_reset_bad_cnt", 64'(bad_cnt), 64'd0);
        for (int p = 0; p < N; p++) exp_q[p].delete();
        bad_m     = 0;
        filt_m    = 0;
        pend_acc  = 1'b0;
        exp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check_outputs();
        logic [N-1:0]    ev;
        logic [N-1:0]    ed;
        logic [N*N-1:0]  em;
        logic [N*PW-1:0] ep;
        ev = '0; ed = '0; em = '0; ep = '0;
        for (int p = 0; p < N; p++) begin
            if (exp_q[p].size() > 0) begin
                ev[p]          = 1'b1;
                ed[p]          = exp_q[p][0].drop;
                em[p*N +: N]   = exp_q[p][0].mask;
                ep[p*PW +: PW] = exp_q[p][0].prio;
            end
        end
        check("in_ready", 64'(bus.in_ready_o), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        check("rsp_mask", 64'(rsp_mask), 64'(em));
        check("rsp_drop", 64'(rsp_drop), 64'(ed));
        check("rsp_prio", 64'(rsp_prio), 64'(ep));
        check("bad_port_cnt", 64'(bad_cnt), 64'(bad_m));
`ifdef SWC_RTU_RSP_DROP_FILTER_EN
        check("filtered_cnt", 64'(filt_cnt), 64'(filt_m));
`endif
        for (int p = 0; p < N; p++) begin
            if (ev[p] && rsp_ack[p]) void'(exp_q[p].pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_outputs();
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks       = 0;
        n_fail         = 0;
        bad_m          = 0;
        filt_m         = 0;
        pend_acc       = 1'b0;
        pend_port      = '0;
        pend_rsp       = '{mask: '0, drop: 1'b0, prio: '0};
        exp_ready      = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_port_i  = '0;
        bus.in_mask_i  = '0;
        bus.in_drop_i  = 1'b0;
        bus.in_prio_i  = '0;
        rsp_ack        = '0;
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;

        // single push to port 2, then pop it
        step(1'b1, 4'd2, 7'h08, 1'b0, 3'd5, '0);
        idle(2, '0);
        idle(1, 7'h04);
        idle(1, '0);

        // invalid port index
        step(1'b1, 4'd9, 7'h11, 1'b0, 3'd1, '0);
        idle(1, '0);

        // fill port 0, check blocking and unblocking after one ack
        for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 7'(i + 1), 1'b0, 3'(i), '0);
        step(1'b1, 4'd0, 7'h40, 1'b0, 3'd7, '0);
        step(1'b1, 4'd3, 7'h22, 1'b1, 3'd2, '0);
        step(1'b1, 4'd0, 7'h40, 1'b0, 3'd7, 7'h01);
        step(1'b1, 4'd0, 7'h40, 1'b0, 3'd7, '0);
        idle(D + 2, '1);

        // same-cycle push and pop on port 1
        step(1'b1, 4'd1, 7'h0A, 1'b0, 3'd1, '0);
        step(1'b1, 4'd1, 7'h0B, 1'b0, 3'd2, '0);
        step(1'b1, 4'd1, 7'h0C, 1'b1, 3'd3, 7'h02);
        idle(4, 7'h02);

        // zero mask and drop flag on a non-full port
        step(1'b1, 4'd5, 7'h00, 1'b0, 3'd4, '0);
        step(1'b1, 4'd5, 7'h7F, 1'b1, 3'd6, '0);
        idle(3, 7'h20);

        // drop=1 offered to a full port
        for (int i = 0; i < 4; i++) step(1'b1, 4'd4, 7'h10, 1'b0, 3'(i), '0);
        step(1'b1, 4'd4, 7'h10, 1'b1, 3'd7, '0);
        step(1'b1, 4'd4, 7'h10, 1'b1, 3'd7, 7'h10);
        step(1'b1, 4'd4, 7'h10, 1'b1, 3'd7, '0);
        idle(D + 2, '1);

        // asynchronous reset with three ports holding entries
        step(1'b1, 4'd0, 7'h01, 1'b0, 3'd1, '0);
        step(1'b1, 4'd1, 7'h02, 1'b0, 3'd2, '0);
        step(1'b1, 4'd6, 7'h40, 1'b0, 3'd3, '0);
        idle(1, '0);
        do_reset();
        idle(3, '1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] m;
            logic [N-1:0] a;
            m = N'($urandom);
            if ($urandom_range(0, 7) == 0) m = '0;
            a = ($urandom_range(0, 3) == 0) ? '1 : (N'($urandom) & N'($urandom));
            step(1'($urandom), 4'($urandom_range(0, 9)), m,
                 ($urandom_range(0, 3) == 0), PW'($urandom), a);
        end
        idle(D + 2, '1);

        // bad-port counter saturation
        for (int i = 0; i < 65536; i++) step(1'b1, 4'd9, 7'h01, 1'b0, 3'd0, '0);
        idle(2, '0);
        check("bad_port_sat", 64'(bad_cnt), 64'(CNT_MAX));

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
